score_display_mux: RTL
======================

// Module: score_display_mux
// PURPOSE
//  Two-player, two-digit-per-player multiplexed 7-segment score driver for pong; successor to the
//  single-digit score block. Converts binary scores (0..99) to BCD with a shared serial
//  double-dabble engine, time-multiplexes 4 digits with a parametrised scan rate, optionally blanks
//  leading zeros, and blinks all digits once either score reaches WIN_SCORE.
// PARAMETERS
//  SCORE_W   7    width of each binary score input; values >99 saturate to 99
//  WIN_SCORE 9    score at/above which game-over blinking starts
//  SCAN_DIV  1    clk cycles each digit stays selected (>=1)
//  BLINK_W   10   blink counter width; display on while counter MSB=1 during game over
//  SEG_ACT   1    segment polarity: 1 = active-high segments, 0 = active-low
// PORTS
//  clk       in   1        clock
//  reset     in   1        synchronous, active-high reset
//  score_p1  in   SCORE_W  player 1 binary score
//  score_p2  in   SCORE_W  player 2 binary score
//  blank_lz  in   1        1 = blank a tens digit that is 0
//  seg       out  7        {g,f,e,d,c,b,a}, registered, polarity per SEG_ACT
//  dig_sel   out  4        one-hot digit enable, registered: [0]=P1 tens,[1]=P1 ones,[2]=P2 tens,[3]=P2 ones
//  busy      out  1        BCD conversion in progress
// BEHAVIOUR
//  Reset: shadow scores=0, BCD regs=00/00, scan idx=0, prescaler=0, blink=0, converter IDLE;
//   dig_sel=4'b0001, seg=all segments off (polarity-correct), busy=0.
//  Change detect: each cycle compare saturated input vs shadow per player. Converter IDLE and
//   a mismatch -> start conversion; P1 wins if both differ; P2 is served on the next start.
//   The shadow is loaded at start; mid-conversion input changes are caught after done.
//  Converter FSM: IDLE -> SHIFT (exactly 7 cycles: add-3 on nibbles >=5, then shift left 1)
//   -> DONE (1 cycle: write 8-bit BCD to that player's display reg) -> IDLE. busy=1 in SHIFT/DONE.
//   Latency from input change (converter idle) to BCD reg update: 9 cycles. Display regs never
//   show partial results.
//  Saturation: input >99 is treated as 99 for conversion and game-over compare.
//  Scan: prescaler counts 0..SCAN_DIV-1; on terminal count idx <= idx+1, wrapping 3->0.
//   dig_sel and seg update on the same edge (1-cycle registered from idx): no ghosting.
//  Digit content: nibble for idx; tens digit blanked if blank_lz=1 and nibble=0; ones never blanked.
//   Decode 0..9 standard; nibbles A..F cannot occur and decode to blank.
//  Game over: go = (sat_p1>=WIN_SCORE)|(sat_p2>=WIN_SCORE) from shadows. Blink counter free-runs
//   whenever not in reset. Digit visible = !go | blink[BLINK_W-1]; invisible -> seg all off, dig_sel
//   still scans. go clears immediately when scores drop below WIN_SCORE (e.g. new game).
//  Reset mid-conversion: aborts, BCD regs return to 00; pending scores reconverted afterwards.
// STRUCTURE
//  Shared package pong_pkg: SEG_W=7, NUM_DIGITS=4, seven_seg decode function, BCD_MAX=99.
//  Sub-module bin2bcd_serial (start, bin[6:0] -> bcd[7:0], done, busy) holds the converter FSM;
//  top holds change detect, arbitration, scan, blink, output regs.
// TESTING
//  1 reset, scores 0/0, blank_lz=0, SCAN_DIV=1: dig_sel cycles 0001,0010,0100,1000; seg=0111111 each.
//  2 score_p1 0->42: busy high 8 cycles; 9 cycles later P1 digits show 1100110 then 1011011.
//  3 blank_lz=1, p2=7: P2 tens slot seg=0000000, ones slot seg=0000111; p2=0: ones shows 0111111.
//  4 p1 and p2 change same cycle (13, 5): P1 converted first, P2 second; both correct after 18 cycles.
//  5 p1=9, BLINK_W=4: seg off for 8 cycles, on for 8, repeating; p1 back to 3 -> steady on.
//  6 p1=120 -> shows 99; assert reset during SHIFT -> next cycle seg off, dig_sel=0001, busy=0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong display definitions: digit/segment geometry, BCD limits,
// converter state encoding and the 7-segment decoder.
package pong_pkg;

  localparam int unsigned SEG_W      = 7;   // {g,f,e,d,c,b,a}
  localparam int unsigned NUM_DIGITS = 4;   // P1 tens, P1 ones, P2 tens, P2 ones
  localparam int unsigned IDX_W      = 2;   // scan index width
  localparam int unsigned BIN_W      = 7;   // binary score after saturation
  localparam int unsigned BCD_W      = 8;   // two BCD nibbles
  localparam int unsigned BCD_MAX    = 99;  // largest displayable score

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Active-high segment pattern; nibbles above 9 decode to blank.
  function automatic logic [SEG_W-1:0] seven_seg(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per cycle.
// Ports:
//   clk, reset  clock, synchronous active-high reset (aborts a conversion)
//   start       accepted only in IDLE; latches bin
//   bin         binary value 0..99
//   bcd         {tens, ones}; valid while done=1
//   done        high for the single DONE cycle
//   busy        high in SHIFT and DONE
module bin2bcd_serial
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done,
  output logic             busy
);

  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = 3;

  conv_state_t     state;
  logic [SR_W-1:0] sr;
  logic [CNT_W-1:0] cnt;

  // One double-dabble iteration: correct each BCD nibble >= 5, then shift.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] a;
    a = v;
    if (a[BIN_W+7:BIN_W+4] >= 4'd5) a[BIN_W+7:BIN_W+4] = a[BIN_W+7:BIN_W+4] + 4'd3;
    if (a[BIN_W+3:BIN_W]   >= 4'd5) a[BIN_W+3:BIN_W]   = a[BIN_W+3:BIN_W]   + 4'd3;
    return {a[SR_W-2:0], 1'b0};
  endfunction

  // Converter FSM with registered done/busy flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CONV_IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {BCD_W'(0), bin};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          sr  <= dabble_step(sr);
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            done  <= 1'b1;
            state <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
      endcase
    end
  end

  assign bcd = sr[SR_W-1:BIN_W];

endmodule

// File: rtl/score_display_mux.sv
// Two-player, two-digit multiplexed 7-segment score driver with shared
// serial BCD conversion, leading-zero blanking and game-over blinking.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   score_p1, score_p2  binary scores; values above 99 display as 99
//   blank_lz            blank a tens digit that is 0
//   seg                 {g,f,e,d,c,b,a}, registered, polarity set by SEG_ACT
//   dig_sel             one-hot digit enable, registered
//                       [0]=P1 tens [1]=P1 ones [2]=P2 tens [3]=P2 ones
//   busy                BCD conversion in progress
module score_display_mux
  import pong_pkg::*;
#(
  parameter int unsigned SCORE_W   = 7,
  parameter int unsigned WIN_SCORE = 9,
  parameter int unsigned SCAN_DIV  = 1,
  parameter int unsigned BLINK_W   = 10,
  parameter bit          SEG_ACT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SCORE_W-1:0]    score_p1,
  input  logic [SCORE_W-1:0]    score_p2,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  busy
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{~SEG_ACT}};

  logic [BIN_W-1:0]   shadow_p1, shadow_p2;
  logic               p2_prio;   // P2 lost the last tie; it goes first next time
  logic               cur_p2;    // player whose conversion is in flight
  bcd_t               bcd_p1, bcd_p2;
  logic [PRE_W-1:0]   pre;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink;

  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_done;
  logic               conv_busy;

  logic [BIN_W-1:0]   sat_p1_c, sat_p2_c;
  logic               p1_diff_c, p2_diff_c;
  logic               start_c, sel_p2_c;
  logic [BIN_W-1:0]   conv_bin_c;
  logic               go_c, vis_c;
  logic [3:0]         nib_c;
  logic               blank_c;
  logic [SEG_W-1:0]   seg_next_c;

  // Saturation, change detection and converter arbitration.
  always_comb begin
    sat_p1_c   = (32'(score_p1) > BCD_MAX) ? BIN_W'(BCD_MAX) : BIN_W'(score_p1);
    sat_p2_c   = (32'(score_p2) > BCD_MAX) ? BIN_W'(BCD_MAX) : BIN_W'(score_p2);
    p1_diff_c  = (sat_p1_c != shadow_p1);
    p2_diff_c  = (sat_p2_c != shadow_p2);
    start_c    = !conv_busy && (p1_diff_c || p2_diff_c);
    sel_p2_c   = p2_diff_c && (!p1_diff_c || p2_prio);
    conv_bin_c = sel_p2_c ? sat_p2_c : sat_p1_c;
  end

  bin2bcd_serial u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_c),
    .bin   (conv_bin_c),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  // Digit content for the current scan slot, including blink and blanking.
  always_comb begin
    go_c  = (shadow_p1 >= BIN_W'(WIN_SCORE)) || (shadow_p2 >= BIN_W'(WIN_SCORE));
    vis_c = !go_c || blink[BLINK_W-1];
    case (idx)
      2'd0:    nib_c = bcd_p1.tens;
      2'd1:    nib_c = bcd_p1.ones;
      2'd2:    nib_c = bcd_p2.tens;
      default: nib_c = bcd_p2.ones;
    endcase
    // Even slots are tens digits; ones digits are never blanked.
    blank_c    = !vis_c || (!idx[0] && blank_lz && (nib_c == 4'd0));
    seg_next_c = blank_c ? SEG_OFF
                         : (SEG_ACT ? seven_seg(nib_c) : ~seven_seg(nib_c));
  end

  // Shadows, display BCD registers, scan, blink and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_p1 <= '0;
      shadow_p2 <= '0;
      p2_prio   <= 1'b0;
      cur_p2    <= 1'b0;
      bcd_p1    <= '0;
      bcd_p2    <= '0;
      pre       <= '0;
      idx       <= '0;
      blink     <= '0;
      seg       <= SEG_OFF;
      dig_sel   <= NUM_DIGITS'(1);
    end else begin
      if (start_c) begin
        cur_p2 <= sel_p2_c;
        if (sel_p2_c) begin
          shadow_p2 <= sat_p2_c;
          p2_prio   <= 1'b0;
        end else begin
          shadow_p1 <= sat_p1_c;
          p2_prio   <= p2_diff_c;
        end
      end

      // Display registers change only on completed conversions.
      if (conv_done) begin
        if (cur_p2) bcd_p2 <= bcd_t'(conv_bcd);
        else        bcd_p1 <= bcd_t'(conv_bcd);
      end

      if (pre == PRE_W'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end

      blink <= blink + BLINK_W'(1);

      // Select and segments are both taken from idx on the same edge.
      dig_sel <= NUM_DIGITS'(1) << idx;
      seg     <= seg_next_c;
    end
  end

  assign busy = conv_busy;

endmodule
